// File: rtl/mem_bus_bridge_pkg.sv
// Shared types for the MEM-stage bus bridge.
//   mb_state_e   : bridge sequencing states (IDLE / BUSY / DONE)
//   word_aligned : true when a byte address selects a whole 32-bit word
package mem_bus_bridge_pkg;

   typedef enum logic [1:0] {
      MB_IDLE = 2'd0,
      MB_BUSY = 2'd1,
      MB_DONE = 2'd2
   } mb_state_e;

   function automatic logic word_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage

// File: rtl/mem_bus_bridge_if.sv
// Single-outstanding strobe/ack data bus between the bridge and the memory slave.
//   stb   : request strobe, held until ack or abandon   (master -> slave)
//   we    : write enable                                  (master -> slave)
//   addr  : word-aligned byte address                     (master -> slave)
//   wdata : store data                                    (master -> slave)
//   rdata : load data, valid with ack                     (slave -> master)
//   ack   : one-cycle completion pulse                    (slave -> master)
interface mem_bus_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic              stb;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;

   modport master (
      output stb, we, addr, wdata,
      input  rdata, ack
   );

   modport slave (
      input  stb, we, addr, wdata,
      output rdata, ack
   );

endinterface

// File: rtl/mem_bus_bridge_watchdog.sv
// Bus watchdog: counts cycles spent waiting for bus_ack.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count at zero
//   en         : count this cycle
//   expired    : the current wait cycle is the last one allowed (count == TIMEOUT-1)
// With TIMEOUT == 0 the watchdog is disabled and expired is tied low.
module mem_bus_bridge_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   generate
      if (TIMEOUT > 0) begin : g_cnt
         localparam int CW = $clog2(TIMEOUT + 1);

         logic [CW-1:0] cnt;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt <= '0;
            end else if (clr) begin
               cnt <= '0;
            end else if (en) begin
               cnt <= cnt + CW'(1);
            end
         end

         // The count is zero in the first wait cycle, so matching TIMEOUT-1
         // flags the TIMEOUT-th wait cycle.
         assign expired = (cnt == CW'(TIMEOUT - 1));
      end else begin : g_off
         logic unused_in;
         assign unused_in = ^{clk, rst_n, clr, en};
         assign expired   = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/mem_bus_bridge.sv
// MEM-stage data-memory bridge for the 5-stage MIPS datapath.
// Turns the MEM-stage load/store request into one strobe/ack bus cycle, stalls
// the pipeline while the access is in flight, returns load data on mem_din and
// reports misaligned addresses and bus timeouts.
//   clk, rst_n           : clock, asynchronous active-low reset
//   mem_ren / mem_wen    : load / store request (store wins if both set)
//   mem_addr, mem_dout   : byte address and store data from the MEM stage
//   mem_adv, mem_flush   : MEM stage advances / is flushed this cycle
//   mem_din              : load data (holds between accesses)
//   mem_stall            : combinational pipeline hold
//   bus                  : strobe/ack bus, master side
//   acc_err, err_addr    : one-cycle error pulse and address of the last error
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no access; a live request starts a bus cycle or a misalign error
// BUSY    | bus_stb high, waiting for bus_ack or the watchdog
// DONE    | access finished, result on mem_din; wait for the stage to move on
module mem_bus_bridge
   import mem_bus_bridge_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_ren,
   input  logic              mem_wen,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_dout,
   input  logic              mem_adv,
   input  logic              mem_flush,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_stall,
   mem_bus_bridge_if.master  bus,
   output logic              acc_err,
   output logic [ADDR_W-1:0] err_addr
);

   mb_state_e         state;
   logic              stb_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              kill_q;

   logic              req;
   logic              kill_now;
   logic              wd_clr;
   logic              wd_en;
   logic              wd_expired;

   assign req = (mem_ren | mem_wen) & ~mem_flush;

   // A flush arriving in the same cycle as the completion still discards the
   // result: the instruction is gone, so DONE must not be entered.
   assign kill_now = kill_q | mem_flush;

   assign wd_clr = (state != MB_BUSY);
   assign wd_en  = (state == MB_BUSY) & ~bus.ack;

   mem_bus_bridge_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   assign bus.stb   = stb_q;
   assign bus.we    = we_q;
   assign bus.addr  = addr_q;
   assign bus.wdata = wdata_q;
   assign mem_din   = rdata_q;

   // Gated by rst_n so the pipeline is released the moment reset asserts,
   // even if a request is still sitting on the MEM-stage inputs.
   always_comb begin
      mem_stall = 1'b0;
      if (rst_n) begin
         case (state)
            MB_IDLE: mem_stall = req;
            MB_BUSY: mem_stall = 1'b1;
            default: mem_stall = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= MB_IDLE;
         stb_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         kill_q   <= 1'b0;
         acc_err  <= 1'b0;
         err_addr <= '0;
      end else begin
         acc_err <= 1'b0;
         case (state)
            MB_IDLE: begin
               if (req) begin
                  if (word_aligned(mem_addr[1:0])) begin
                     stb_q   <= 1'b1;
                     we_q    <= mem_wen;
                     addr_q  <= {mem_addr[ADDR_W-1:2], 2'b00};
                     wdata_q <= mem_dout;
                     kill_q  <= 1'b0;
                     state   <= MB_BUSY;
                  end else begin
                     acc_err  <= 1'b1;
                     err_addr <= mem_addr;
                     rdata_q  <= '0;
                     state    <= MB_DONE;
                  end
               end
            end

            MB_BUSY: begin
               // The bus cycle runs to completion even when flushed so a store
               // is never torn; the flush only decides where we land.
               if (mem_flush) begin
                  kill_q <= 1'b1;
               end
               if (bus.ack) begin
                  stb_q <= 1'b0;
                  if (!we_q) begin
                     rdata_q <= bus.rdata;
                  end
                  state <= kill_now ? MB_IDLE : MB_DONE;
               end else if (wd_expired) begin
                  stb_q    <= 1'b0;
                  acc_err  <= 1'b1;
                  err_addr <= addr_q;
                  rdata_q  <= '0;
                  state    <= kill_now ? MB_IDLE : MB_DONE;
               end
            end

            MB_DONE: begin
               // The request still present here is the instruction just served.
               if (mem_adv | mem_flush) begin
                  state <= MB_IDLE;
               end
            end

            default: state <= MB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_bridge.sv
module tb_mem_bus_bridge;

   localparam int TMO = 8;

   logic        clk;
   logic        rst_n;
   logic        mem_ren, mem_wen, mem_adv, mem_flush;
   logic [31:0] mem_addr, mem_dout, mem_din, err_addr;
   logic        mem_stall, acc_err;

   mem_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

   mem_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_ren   (mem_ren),
      .mem_wen   (mem_wen),
      .mem_addr  (mem_addr),
      .mem_dout  (mem_dout),
      .mem_adv   (mem_adv),
      .mem_flush (mem_flush),
      .mem_din   (mem_din),
      .mem_stall (mem_stall),
      .bus       (bus_if),
      .acc_err   (acc_err),
      .err_addr  (err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          stall;
      bit          stb;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] din;
      bit          err;
      logic [31:0] err_addr;
   } cyc_t;

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } pin_t;

   cyc_t cq[$];
   pin_t pq[$];

   int nchecks = 0;
   int nfail = 0;
   int stall_seen = 0;
   int bursts = 0;
   int err_seen = 0;
   bit prev_stb = 1'b0;
   cyc_t ce;
   pin_t pe;

   // Transaction-level expectation of the registered outputs for the next cycle.
   bit          m_stb, m_we, m_err;
   logic [31:0] m_addr, m_wdata, m_din, m_err_addr;
   bit          fix_rd;
   logic [31:0] fix_rd_val;
   int          s_stall, s_burst, s_err;

   function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
      nchecks++;
      if (a !== e) begin
         nfail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", n, a, e);
      end
   endfunction

   always @(negedge clk) begin
      if (cq.size() > 0) begin
         ce = cq.pop_front();
         chk("mem_stall", 32'(mem_stall), 32'(ce.stall));
         chk("bus_stb", 32'(bus_if.stb), 32'(ce.stb));
         chk("bus_we", 32'(bus_if.we), 32'(ce.we));
         chk("bus_addr", bus_if.addr, ce.addr);
         chk("bus_wdata", bus_if.wdata, ce.wdata);
         chk("mem_din", mem_din, ce.din);
         chk("acc_err", 32'(acc_err), 32'(ce.err));
         chk("err_addr", err_addr, ce.err_addr);
         stall_seen += int'(mem_stall);
         err_seen   += int'(acc_err);
         if (bus_if.stb && !prev_stb) bursts++;
         prev_stb = bus_if.stb;
      end
      while (pq.size() > 0) begin
         pe = pq.pop_front();
         chk(pe.name, pe.act, pe.exp);
      end
   end

   task automatic pin(input string n, input logic [31:0] a, input logic [31:0] e);
      pin_t p;
      p.name = n;
      p.act  = a;
      p.exp  = e;
      pq.push_back(p);
   endtask

   task automatic push(input bit stall);
      cyc_t c;
      c.stall    = stall;
      c.stb      = m_stb;
      c.we       = m_we;
      c.addr     = m_addr;
      c.wdata    = m_wdata;
      c.din      = m_din;
      c.err      = m_err;
      c.err_addr = m_err_addr;
      cq.push_back(c);
      m_err = 1'b0;
   endtask

   task automatic model_reset();
      m_stb = 0; m_we = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_din = '0; m_err_addr = '0;
   endtask

   task automatic drive_idle();
      mem_ren = 0; mem_wen = 0; mem_adv = 0; mem_flush = 0;
      bus_if.ack = 0;
   endtask

   task automatic drive_req(input bit is_st, input logic [31:0] addr, input logic [31:0] wd);
      mem_wen  = is_st;
      mem_ren  = is_st ? 1'($urandom_range(0, 1)) : 1'b1;
      mem_addr = addr;
      mem_dout = wd;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic snap();
      s_stall = stall_seen;
      s_burst = bursts;
      s_err   = err_seen;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if ($urandom_range(0, 1) != 0) begin
            mem_ren   = 1'b1;
            mem_wen   = 1'($urandom_range(0, 1));
            mem_flush = 1'b1;
         end else begin
            mem_ren   = 1'b0;
            mem_wen   = 1'b0;
            mem_flush = 1'($urandom_range(0, 1));
         end
         mem_addr     = $urandom;
         mem_dout     = $urandom;
         mem_adv      = 1'($urandom_range(0, 1));
         bus_if.ack   = ($urandom_range(0, 3) == 0);
         bus_if.rdata = $urandom;
         push(1'b0);
      end
   endtask

   task automatic done_phase(input bit is_st, input logic [31:0] addr, input logic [31:0] wd,
                             input int h, input bit exit_flush);
      for (int j = 0; j <= h; j++) begin
         @(posedge clk);
         #1;
         drive_req(is_st, addr, wd);
         mem_adv      = (j == h) && !exit_flush;
         mem_flush    = (j == h) && exit_flush;
         bus_if.ack   = ($urandom_range(0, 3) == 0);
         bus_if.rdata = $urandom;
         push(1'b0);
      end
   endtask

   task automatic mid_reset();
      rst_n = 1'b0;
      #1;
      pin("rst_bus_stb", 32'(bus_if.stb), 32'd0);
      pin("rst_mem_stall", 32'(mem_stall), 32'd0);
      pin("rst_mem_din", mem_din, 32'd0);
      pin("rst_acc_err", 32'(acc_err), 32'd0);
      pin("rst_err_addr", err_addr, 32'd0);
      pin("rst_bus_addr", bus_if.addr, 32'd0);
      @(posedge clk);
      #1;
      pin("rst_hold_stb", 32'(bus_if.stb), 32'd0);
      drive_idle();
      model_reset();
      rst_n = 1'b1;
   endtask

   // d: BUSY cycle carrying bus_ack (outside 1..TMO means the slave never answers)
   // f: BUSY cycle carrying mem_flush (0 = none); h: DONE cycles before leaving
   task automatic run_tx(input bit is_st, input logic [31:0] addr, input logic [31:0] wd,
                         input int d, input int f, input int h, input bit exit_flush,
                         input int rst_at);
      bit          acked, killed;
      int          blen;
      logic [31:0] cap;
      acked  = (d >= 1) && (d <= TMO);
      blen   = acked ? d : TMO;
      killed = 1'b0;
      cap    = '0;
      @(posedge clk);
      #1;
      drive_req(is_st, addr, wd);
      mem_flush    = 1'b0;
      mem_adv      = 1'($urandom_range(0, 1));
      bus_if.ack   = ($urandom_range(0, 3) == 0);
      bus_if.rdata = $urandom;
      push(1'b1);
      if (addr[1:0] != 2'b00) begin
         m_err = 1'b1; m_err_addr = addr; m_din = '0;
         done_phase(is_st, addr, wd, h, exit_flush);
      end else begin
         m_stb = 1'b1; m_we = is_st; m_addr = addr; m_wdata = wd;
         for (int k = 1; k <= blen; k++) begin
            @(posedge clk);
            #1;
            if (k == rst_at) begin
               mid_reset();
               return;
            end
            mem_ren   = 1'($urandom_range(0, 1));
            mem_wen   = 1'($urandom_range(0, 1));
            mem_addr  = $urandom;
            mem_dout  = $urandom;
            mem_adv   = 1'($urandom_range(0, 1));
            mem_flush = (k == f);
            if (k == f) killed = 1'b1;
            bus_if.ack   = acked && (k == blen);
            bus_if.rdata = (fix_rd && acked && (k == blen)) ? fix_rd_val : $urandom;
            if (acked && (k == blen)) cap = bus_if.rdata;
            push(1'b1);
         end
         m_stb = 1'b0;
         if (acked) begin
            if (!is_st) m_din = cap;
         end else begin
            m_err = 1'b1; m_err_addr = addr; m_din = '0;
         end
         if (!killed) done_phase(is_st, addr, wd, h, exit_flush);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, want finish before limit");
      $fatal(1, "bench time limit");
   end

   initial begin
      drive_idle();
      mem_addr = '0; mem_dout = '0; bus_if.rdata = '0;
      fix_rd = 1'b0; fix_rd_val = '0;
      model_reset();
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      pin("init_bus_stb", 32'(bus_if.stb), 32'd0);
      pin("init_mem_stall", 32'(mem_stall), 32'd0);
      pin("init_mem_din", mem_din, 32'd0);
      pin("init_acc_err", 32'(acc_err), 32'd0);
      pin("init_err_addr", err_addr, 32'd0);
      pin("init_bus_addr", bus_if.addr, 32'd0);
      pin("init_bus_wdata", bus_if.wdata, 32'd0);
      rst_n = 1'b1;

      gap(2);
      settle(); snap();

      // zero-wait load
      fix_rd = 1'b1; fix_rd_val = 32'h1234_5678;
      run_tx(1'b0, 32'h10, $urandom, 1, 0, 0, 1'b0, 0);
      fix_rd = 1'b0;
      settle();
      pin("t1_stall_cycles", stall_seen - s_stall, 32'd2);
      pin("t1_mem_din", mem_din, 32'h1234_5678);
      pin("t1_bus_we", 32'(bus_if.we), 32'd0);
      pin("t1_bursts", bursts - s_burst, 32'd1);
      snap();

      // store with four-cycle ack
      run_tx(1'b1, 32'h20, 32'hCAFE_BABE, 4, 0, 1, 1'b0, 0);
      settle();
      pin("t2_stall_cycles", stall_seen - s_stall, 32'd5);
      pin("t2_bursts", bursts - s_burst, 32'd1);
      pin("t2_bus_wdata", bus_if.wdata, 32'hCAFE_BABE);
      pin("t2_bus_addr", bus_if.addr, 32'h20);
      snap();

      // misaligned load
      run_tx(1'b0, 32'h13, $urandom, 1, 0, 0, 1'b0, 0);
      settle();
      pin("t3_stall_cycles", stall_seen - s_stall, 32'd1);
      pin("t3_bursts", bursts - s_burst, 32'd0);
      pin("t3_err_pulses", err_seen - s_err, 32'd1);
      pin("t3_err_addr", err_addr, 32'h13);
      pin("t3_mem_din", mem_din, 32'd0);
      snap();

      // slave never answers
      run_tx(1'b0, 32'h40, $urandom, 0, 0, 0, 1'b0, 0);
      settle();
      pin("t4_stall_cycles", stall_seen - s_stall, 32'd9);
      pin("t4_err_pulses", err_seen - s_err, 32'd1);
      pin("t4_mem_din", mem_din, 32'd0);
      pin("t4_err_addr", err_addr, 32'h40);
      snap();

      // flushed store, ack in third BUSY cycle; next request must be seen in IDLE at once
      run_tx(1'b1, 32'h24, 32'h5555_AAAA, 3, 2, 0, 1'b0, 0);
      settle();
      pin("t5_stall_cycles", stall_seen - s_stall, 32'd4);
      pin("t5_bursts", bursts - s_burst, 32'd1);
      pin("t5_err_pulses", err_seen - s_err, 32'd0);
      pin("t5_bus_we", 32'(bus_if.we), 32'd1);
      snap();

      // DONE held for three cycles without advance
      run_tx(1'b0, 32'h30, $urandom, 2, 0, 3, 1'b0, 0);
      settle();
      pin("t7_stall_cycles", stall_seen - s_stall, 32'd3);
      pin("t7_bursts", bursts - s_burst, 32'd1);

      // reset in the middle of BUSY, then a normal load
      run_tx(1'b0, 32'h50, $urandom, 0, 0, 0, 1'b0, 3);
      settle();
      snap();
      fix_rd = 1'b1; fix_rd_val = 32'h0BAD_F00D;
      run_tx(1'b0, 32'h10, $urandom, 1, 0, 0, 1'b0, 0);
      fix_rd = 1'b0;
      settle();
      pin("t6_stall_cycles", stall_seen - s_stall, 32'd2);
      pin("t6_mem_din", mem_din, 32'h0BAD_F00D);

      for (int t = 0; t < 40; t++) begin
         bit          st;
         logic [31:0] a;
         int          d, f;
         gap($urandom_range(0, 2));
         st = 1'($urandom_range(0, 1));
         a  = $urandom;
         if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
         else if (a[1:0] == 2'b00) a[0] = 1'b1;
         d = $urandom_range(0, TMO + 2);
         f = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TMO) : 0;
         run_tx(st, a, $urandom, d, f, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
      end

      settle();
      settle();
      $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
      $finish;
   end

endmodule
